// File: rtl/indicator_write_arbiter.sv
// rtl/indicator_write_arbiter.sv - round-robin arbiter writing a 16-bit indicator word as four nibble writes
module indicator_write_arbiter #(
  parameter int GAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] word_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] word_b,
  output logic        ack_b,
  output logic        busy,
  output logic        rw,
  output logic [3:0]  Data,
  output logic [1:0]  PortID
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

  localparam logic [2:0] GAP_LAST = (GAP == 0) ? 3'd0 : 3'(GAP - 1);

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [2:0]  gcnt, gcnt_nx;
  logic [15:0] hold, hold_nx;
  logic        last_b, last_b_nx;
  logic        grant_a;
  logic        rw_nx, ack_a_nx, ack_b_nx;
  logic [3:0]  data_nx;
  logic [1:0]  port_nx;
  logic [15:0] shifted;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    gcnt_nx   = gcnt;
    hold_nx   = hold;
    last_b_nx = last_b;
    // A wins unless B is also requesting and A was granted last
    grant_a   = req_a & (~req_b | last_b);

    case (state)
      S_IDLE: begin
        if (req_a | req_b) begin
          state_nx  = S_WRITE;
          cnt_nx    = 2'd0;
          gcnt_nx   = 3'd0;
          hold_nx   = grant_a ? word_a : word_b;
          last_b_nx = ~grant_a;
        end
      end
      S_WRITE: begin
        if (cnt == 2'd3) begin
          state_nx = S_DONE;
        end else begin
          cnt_nx   = cnt + 2'd1;
          gcnt_nx  = 3'd0;
          state_nx = (GAP == 0) ? S_WRITE : S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) state_nx = S_WRITE;
        else                  gcnt_nx  = gcnt + 3'd1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // outputs are precomputed from next-state values and registered below
    shifted  = hold_nx >> {cnt_nx, 2'b00};
    rw_nx    = (state_nx == S_WRITE);
    port_nx  = rw_nx ? cnt_nx : 2'd0;
    data_nx  = rw_nx ? shifted[3:0] : 4'd0;
    ack_a_nx = (state_nx == S_DONE) & ~last_b_nx;
    ack_b_nx = (state_nx == S_DONE) &  last_b_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      gcnt   <= 3'd0;
      hold   <= 16'd0;
      last_b <= 1'b1;
      rw     <= 1'b0;
      Data   <= 4'd0;
      PortID <= 2'd0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      gcnt   <= gcnt_nx;
      hold   <= hold_nx;
      last_b <= last_b_nx;
      rw     <= rw_nx;
      Data   <= data_nx;
      PortID <= port_nx;
      ack_a  <= ack_a_nx;
      ack_b  <= ack_b_nx;
      busy   <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_indicator_write_arbiter.sv
// tb/tb_indicator_write_arbiter.sv - checks GAP=0 and GAP=2 instances against a schedule-based model
module tb_indicator_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] word_a = 16'd0, word_b = 16'd0;
  logic [1:0]  ack_a_o, ack_b_o, busy_o, rw_o;
  logic [3:0]  data_o [2];
  logic [1:0]  port_o [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  indicator_write_arbiter #(.GAP(0)) u_g0 (
    .clk(clk), .reset(reset),
    .req_a(req_a), .word_a(word_a), .ack_a(ack_a_o[0]),
    .req_b(req_b), .word_b(word_b), .ack_b(ack_b_o[0]),
    .busy(busy_o[0]), .rw(rw_o[0]), .Data(data_o[0]), .PortID(port_o[0])
  );

  indicator_write_arbiter #(.GAP(2)) u_g2 (
    .clk(clk), .reset(reset),
    .req_a(req_a), .word_a(word_a), .ack_a(ack_a_o[1]),
    .req_b(req_b), .word_b(word_b), .ack_b(ack_b_o[1]),
    .busy(busy_o[1]), .rw(rw_o[1]), .Data(data_o[1]), .PortID(port_o[1])
  );

  // Model: a transfer is a fixed timeline of 5+3G cycles after the grant edge;
  // offset k carries a write when (k-1) is a multiple of G+1, ack at the last offset.
  int          gaps [2] = '{0, 2};
  bit          m_active [2];
  int          m_k [2];
  bit          m_lastb [2];
  logic [15:0] m_word [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_active[i] = 1'b0;
        m_k[i]      = 0;
        m_lastb[i]  = 1'b1;
        m_word[i]   = 16'd0;
      end else if (!m_active[i]) begin
        if (req_a || req_b) begin
          bit ga;
          ga          = req_a && (!req_b || m_lastb[i]);
          m_lastb[i]  = !ga;
          m_word[i]   = ga ? word_a : word_b;
          m_active[i] = 1'b1;
          m_k[i]      = 1;
        end
      end else if (m_k[i] == 5 + 3 * gaps[i]) begin
        m_active[i] = 1'b0;
        m_k[i]      = 0;
      end else begin
        m_k[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int   g;
      bit   rw_e, ack_e;
      int   n;
      logic [31:0] d_e, p_e;
      g     = gaps[i];
      rw_e  = m_active[i] && (m_k[i] <= 4 + 3 * g) && (((m_k[i] - 1) % (g + 1)) == 0);
      ack_e = m_active[i] && (m_k[i] == 5 + 3 * g);
      d_e   = 0;
      p_e   = 0;
      if (rw_e) begin
        n   = (m_k[i] - 1) / (g + 1);
        p_e = n;
        d_e = (32'(m_word[i]) >> (4 * n)) & 32'hF;
      end
      chk($sformatf("g%0d_busy@%0t", g, $time), 32'(busy_o[i]), 32'(m_active[i]));
      chk($sformatf("g%0d_rw@%0t", g, $time), 32'(rw_o[i]), 32'(rw_e));
      chk($sformatf("g%0d_portid@%0t", g, $time), 32'(port_o[i]), p_e);
      chk($sformatf("g%0d_data@%0t", g, $time), 32'(data_o[i]), d_e);
      chk($sformatf("g%0d_ack_a@%0t", g, $time), 32'(ack_a_o[i]), 32'(ack_e && !m_lastb[i]));
      chk($sformatf("g%0d_ack_b@%0t", g, $time), 32'(ack_b_o[i]), 32'(ack_e && m_lastb[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] rebuilt;
    int          cnt_rw, cnt_ack, or_data;
    int          ack_seq [$];
    int          rw_off [$];
    int          ack_off;

    // reset state
    reset = 1'b0;
    repeat (2) tick();
    chk("reset_busy", 32'(busy_o[0]), 32'd0);
    reset = 1'b1;
    tick();

    // A5C3 on GAP=0: nibbles 3,C,5,A then ack_a at t+5
    req_a = 1'b1; word_a = 16'hA5C3;
    tick();
    req_a = 1'b0;
    rebuilt = 16'd0; cnt_rw = 0; cnt_ack = 0; ack_off = -1;
    for (int c = 1; c <= 13; c++) begin
      if (rw_o[0]) rebuilt[4 * port_o[0] +: 4] = data_o[0];
      if (rw_o[0]) cnt_rw++;
      if (ack_a_o[0]) begin cnt_ack++; ack_off = c; end
      tick();
    end
    chk("a5c3_word", 32'(rebuilt), 32'hA5C3);
    chk("a5c3_rw_count", cnt_rw, 4);
    chk("a5c3_ack_count", cnt_ack, 1);
    chk("a5c3_ack_offset", ack_off, 5);

    // contention after reset: a, b, a
    reset = 1'b0; tick(); reset = 1'b1; tick();
    req_a = 1'b1; req_b = 1'b1; word_a = 16'h1111; word_b = 16'h2222;
    for (int c = 0; c < 18; c++) begin
      tick();
      if (ack_a_o[0]) ack_seq.push_back(1);
      if (ack_b_o[0]) ack_seq.push_back(2);
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("rr_ack_count", ack_seq.size(), 3);
    if (ack_seq.size() >= 3) begin
      chk("rr_first", ack_seq[0], 1);
      chk("rr_second", ack_seq[1], 2);
      chk("rr_third", ack_seq[2], 1);
    end
    repeat (16) tick();

    // GAP=2 timing with 1234
    req_b = 1'b1; word_b = 16'h1234;
    tick();
    req_b = 1'b0;
    ack_off = -1;
    for (int c = 1; c <= 14; c++) begin
      if (rw_o[1]) rw_off.push_back(c);
      if (ack_b_o[1]) ack_off = c;
      tick();
    end
    chk("gap2_rw_count", rw_off.size(), 4);
    if (rw_off.size() == 4) begin
      chk("gap2_rw0", rw_off[0], 1);
      chk("gap2_rw1", rw_off[1], 4);
      chk("gap2_rw2", rw_off[2], 7);
      chk("gap2_rw3", rw_off[3], 10);
    end
    chk("gap2_ack", ack_off, 11);

    // word change after grant ignored
    req_a = 1'b1; word_a = 16'h0000;
    tick();
    word_a = 16'hFFFF; req_a = 1'b0;
    or_data = 0; cnt_rw = 0;
    for (int c = 0; c < 14; c++) begin
      if (rw_o[0]) begin or_data |= int'(data_o[0]); cnt_rw++; end
      tick();
    end
    chk("hold_data_zero", or_data, 0);
    chk("hold_rw_count", cnt_rw, 4);

    // reset during nibble 2 abandons the transfer
    req_a = 1'b1; word_a = 16'hBEEF;
    tick();
    req_a = 1'b0;
    repeat (2) tick();
    chk("pre_reset_portid", 32'(port_o[0]), 32'd2);
    reset = 1'b0;
    tick();
    chk("mid_reset_rw", 32'(rw_o[0]), 32'd0);
    chk("mid_reset_busy", 32'(busy_o[0]), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    req_a = 1'b1; word_a = 16'hCAFE;
    tick();
    chk("fresh_portid", 32'(port_o[0]), 32'd0);
    chk("fresh_data", 32'(data_o[0]), 32'hE);
    req_a = 1'b0;
    repeat (14) tick();

    // req dropped after first nibble still completes once
    req_a = 1'b1; word_a = 16'h5A5A;
    tick();
    tick();
    req_a = 1'b0;
    cnt_ack = 0;
    for (int c = 0; c < 14; c++) begin
      if (ack_a_o[0]) cnt_ack++;
      tick();
    end
    chk("drop_ack_count", cnt_ack, 1);
    chk("drop_idle", 32'(busy_o[0]), 32'd0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      reset  = ($urandom_range(0, 99) != 0);
      req_a  = ($urandom_range(0, 2) != 0);
      req_b  = ($urandom_range(0, 2) != 0);
      word_a = 16'($urandom);
      word_b = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
